// File: rtl/sram_ctrl.sv
// sram_ctrl: asynchronous SRAM access controller for the MEM pipeline stage.
// A read or write request from the EX/MEM register runs a fixed-length SRAM
// bus sequence. The pipeline is held through stall_out until the
// one-cycle DONE state.
//
// Parameters:
//   WAIT_CYCLES  number of SRAM access cycles beyond the first (0..7)
//
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   memread_in, memwrite_in      access requests (write wins if both are set)
//   addr_in, wdata_in            word address and write data; latched when IDLE is left
//   rdata_out                    last completed read data
//   done_out                     one-cycle completion pulse
//   stall_out                    pipeline hold request
//   ram_addr, ram_data           SRAM address and bidirectional data bus
//   ram_ce_n, ram_oe_n, ram_we_n SRAM strobes, all active-low
//
// Optional feature: define SRAM_CTRL_RDCACHE_EN to add a one-entry read cache.
// A read hit goes straight from IDLE to DONE without any SRAM activity.
module sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread_in,
  input  logic        memwrite_in,
  input  logic [15:0] addr_in,
  input  logic [15:0] wdata_in,
  output logic [15:0] rdata_out,
  output logic        done_out,
  output logic        stall_out,
  output logic [17:0] ram_addr,
  inout  wire  [15:0] ram_data,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n
);

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWrSetup,
    StWrPulse,
    StWrHold,
    StDone
  } state_e;

  // Last counter value of the stretched RD / WR_PULSE states.
  localparam logic [2:0] LastCnt = 3'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        drive;
  logic        cache_hit;
  logic [15:0] cache_data;

`ifdef SRAM_CTRL_RDCACHE_EN
  logic        cache_valid_q, cache_valid_d;
  logic [15:0] cache_tag_q, cache_tag_d;
  logic [15:0] cache_data_q, cache_data_d;

  assign cache_hit  = cache_valid_q && (cache_tag_q == addr_in);
  assign cache_data = cache_data_q;

  always_comb begin
    cache_valid_d = cache_valid_q;
    cache_tag_d   = cache_tag_q;
    cache_data_d  = cache_data_q;
    // Any write may alias the cached word, so drop it as the write starts.
    if (state_q == StIdle && state_d == StWrSetup) begin
      cache_valid_d = 1'b0;
    end
    if (state_q == StRd && state_d == StDone) begin
      cache_valid_d = 1'b1;
      cache_tag_d   = addr_q;
      cache_data_d  = ram_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cache_valid_q <= 1'b0;
      cache_tag_q   <= '0;
      cache_data_q  <= '0;
    end else begin
      cache_valid_q <= cache_valid_d;
      cache_tag_q   <= cache_tag_d;
      cache_data_q  <= cache_data_d;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 3'd1;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (memwrite_in) begin
          state_d = StWrSetup;
          addr_d  = addr_in;
          wdata_d = wdata_in;
        end else if (memread_in) begin
          addr_d  = addr_in;
          wdata_d = wdata_in;
          if (cache_hit) begin
            state_d = StDone;
            rdata_d = cache_data;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: begin
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          rdata_d = ram_data;
        end
      end
      StWrSetup: state_d = StWrPulse;
      StWrPulse: begin
        if (cnt_q == LastCnt) begin
          state_d = StWrHold;
        end
      end
      StWrHold: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    // The counter measures time spent in the current state only.
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // SRAM strobes decode straight from the state, so a reset that lands mid-write
  // releases we_n in the same cycle that the state returns to IDLE.
  always_comb begin
    ram_ce_n = 1'b1;
    ram_oe_n = 1'b1;
    ram_we_n = 1'b1;
    drive    = 1'b0;
    done_out = 1'b0;
    unique case (state_q)
      StRd: begin
        ram_ce_n = 1'b0;
        ram_oe_n = 1'b0;
      end
      StWrSetup: begin
        ram_ce_n = 1'b0;
        drive    = 1'b1;
      end
      StWrPulse: begin
        ram_ce_n = 1'b0;
        ram_we_n = 1'b0;
        drive    = 1'b1;
      end
      StWrHold: begin
        ram_ce_n = 1'b0;
        drive    = 1'b1;
      end
      StDone:  done_out = 1'b1;
      default: ;
    endcase
  end

  assign ram_data  = drive ? wdata_q : 16'hzzzz;
  assign ram_addr  = {2'b00, addr_q};
  assign rdata_out = rdata_q;
  // The pipeline advances only in the DONE cycle. It is never held while in reset.
  assign stall_out = rst & (memread_in | memwrite_in) & (state_q != StDone);

endmodule
